// File: rtl/hint_mem_resolver.sv
// ---------------------------------------------------------------------------
// hint_mem_resolver
//
// Resolves up to NUM_OPNDS memory read operands against a bank of NUM_HINTS
// memory hints. It processes one operand slot per cycle. Each read hint can
// be consumed only once. Operand values are masked to the operand size. The
// response flags any memory operand that found no hint (rsp_miss) and any
// valid read hint that no operand consumed (rsp_unused). The downstream
// proof logic uses these two flags to reject inconsistent witnesses.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   req_valid/ready request handshake; ready is high only in IDLE
//   req_is_mem      per-slot flag: the operand is a memory read
//   req_addr        per-slot effective address, slot i at [i*ADDR_W +: ADDR_W]
//   req_size        per-slot size: 00 byte, 01 word, 10 dword, 11 reserved
//   hint_valid      per-hint flag: the hint is present
//   hint_is_write   per-hint flag: the hint is a write and never matches
//   hint_address    per-hint address
//   hint_data       per-hint data
//   rsp_valid/ready response handshake
//   rsp_val         per-slot resolved value
//   rsp_hit         per-slot match flag
//   rsp_hint_used   per-hint consumed flag
//   rsp_miss        a memory operand was unmatched or had the reserved size
//   rsp_unused      a valid read hint was left unconsumed
// ---------------------------------------------------------------------------
module hint_mem_resolver #(
  parameter int NUM_OPNDS = 3,
  parameter int NUM_HINTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NUM_OPNDS-1:0]          req_is_mem,
  input  logic [NUM_OPNDS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_OPNDS*2-1:0]        req_size,
  input  logic [NUM_HINTS-1:0]          hint_valid,
  input  logic [NUM_HINTS-1:0]          hint_is_write,
  input  logic [NUM_HINTS*ADDR_W-1:0]   hint_address,
  input  logic [NUM_HINTS*DATA_W-1:0]   hint_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NUM_OPNDS*DATA_W-1:0]   rsp_val,
  output logic [NUM_OPNDS-1:0]          rsp_hit,
  output logic [NUM_HINTS-1:0]          rsp_hint_used,
  output logic                          rsp_miss,
  output logic                          rsp_unused
);

  localparam int CNT_W = (NUM_OPNDS > 1) ? $clog2(NUM_OPNDS) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_OPNDS - 1);

  typedef enum logic [1:0] {IDLE, RESOLVE, RESP} state_t;

  state_t state, state_next;

  // Copy of the request and the hint bank, taken at acceptance.
  logic [NUM_OPNDS-1:0]             is_mem_q;
  logic [NUM_OPNDS-1:0][ADDR_W-1:0] addr_q;
  logic [NUM_OPNDS-1:0][1:0]        size_q;
  logic [NUM_HINTS-1:0]             hint_valid_q;
  logic [NUM_HINTS-1:0]             hint_write_q;
  logic [NUM_HINTS-1:0][ADDR_W-1:0] hint_addr_q;
  logic [NUM_HINTS-1:0][DATA_W-1:0] hint_data_q;

  // Result registers. These drive the response ports directly.
  logic [NUM_OPNDS-1:0][DATA_W-1:0] val_q;
  logic [NUM_OPNDS-1:0]             hit_q;
  logic [NUM_HINTS-1:0]             used_q;
  logic                             miss_q;
  logic                             unused_q;
  logic [CNT_W-1:0]                 cnt_q;

  logic                 accept;
  logic [NUM_HINTS-1:0] match_oh;
  logic                 found;
  logic [DATA_W-1:0]    match_data;
  logic                 slot_hit;
  logic                 slot_miss;
  logic [DATA_W-1:0]    slot_val;
  logic [NUM_HINTS-1:0] used_next;

  function automatic logic [DATA_W-1:0] size_mask(input logic [DATA_W-1:0] d,
                                                  input logic [1:0]        sz);
    case (sz)
      2'b00:   return DATA_W'(d[7:0]);
      2'b01:   return DATA_W'(d[15:0]);
      default: return DATA_W'(d[31:0]);
    endcase
  endfunction

  assign accept = req_valid && (state == IDLE);

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state always uses non-blocking assignments. Every flop
  // then samples pre-edge values, no matter what order the blocks run in.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: each variable gets a default before any branch. Without it a path
  // that skips the assignment would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid)          state_next = RESOLVE;
      RESOLVE: if (cnt_q == LAST_SLOT) state_next = RESP;
      RESP:    if (rsp_ready)          state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  assign rsp_val       = val_q;
  assign rsp_hit       = hit_q;
  assign rsp_hint_used = used_q;
  assign rsp_miss      = miss_q;
  assign rsp_unused    = unused_q;

  // ---------------- Current slot lookup ----------------
  // The lowest-indexed free read hint with an equal address wins. Earlier
  // slots have already marked their hints as used, so duplicate addresses
  // consume distinct hints in slot order.
  always_comb begin
    match_oh   = '0;
    found      = 1'b0;
    match_data = '0;
    for (int j = 0; j < NUM_HINTS; j++) begin
      if (!found && hint_valid_q[j] && !hint_write_q[j] && !used_q[j] &&
          (hint_addr_q[j] == addr_q[cnt_q])) begin
        match_oh[j] = 1'b1;
        found       = 1'b1;
        match_data  = hint_data_q[j];
      end
    end
    // A reserved size neither matches nor consumes a hint.
    slot_hit  = is_mem_q[cnt_q] && (size_q[cnt_q] != 2'b11) && found;
    slot_miss = is_mem_q[cnt_q] && !slot_hit;
    slot_val  = slot_hit ? size_mask(match_data, size_q[cnt_q]) : '0;
    used_next = used_q | (slot_hit ? match_oh : '0);
  end

  // ---------------- Request capture ----------------
  // NOTE: the request and hint copies are pure data and are always loaded
  // before use, so they have no reset. Only control and result state are
  // reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_mem_q     <= req_is_mem;
      addr_q       <= req_addr;
      size_q       <= req_size;
      hint_valid_q <= hint_valid;
      hint_write_q <= hint_is_write;
      hint_addr_q  <= hint_address;
      hint_data_q  <= hint_data;
    end
  end

  // ---------------- Results and slot counter ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q    <= '0;
      hit_q    <= '0;
      used_q   <= '0;
      miss_q   <= 1'b0;
      unused_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            val_q    <= '0;
            hit_q    <= '0;
            used_q   <= '0;
            miss_q   <= 1'b0;
            unused_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        RESOLVE: begin
          val_q[cnt_q] <= slot_val;
          hit_q[cnt_q] <= slot_hit;
          used_q       <= used_next;
          if (slot_miss) miss_q <= 1'b1;
          if (cnt_q == LAST_SLOT)
            unused_q <= |(hint_valid_q & ~hint_write_q & ~used_next);
          else
            cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
